// File: rtl/vera_fx_pkg.sv
// vera_fx_pkg: shared types and constants for the fx multiply result writer
//   fx_wr_state_t      writer FSM states
//   FX_BYTES_PER_WORD  bytes in one MAC result word
//   FX_BYTE_IDX_W      width of a byte index within the word
package vera_fx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPTURE,
        SEL,
        WRITE,
        FIN
    } fx_wr_state_t;

    localparam int FX_BYTES_PER_WORD = 4;
    localparam int FX_BYTE_IDX_W     = 2;

endpackage

// File: rtl/fx_byte_pick.sv
// fx_byte_pick: lowest-set-bit priority encoder over the remaining byte mask
//   mask  in   4   bytes still to be written
//   data  in   32  captured result word
//   idx   out  2   index of the lowest eligible byte
//   any   out  1   at least one eligible byte remains
// With FX_MULT_TRANSPARENT_EN defined, bytes equal to 8'h00 are not eligible.
module fx_byte_pick
    import vera_fx_pkg::*;
(
    input  logic [FX_BYTES_PER_WORD-1:0] mask,
    input  logic [31:0]                  data,
    output logic [FX_BYTE_IDX_W-1:0]     idx,
    output logic                         any
);
    logic [FX_BYTES_PER_WORD-1:0] eff;
`ifdef FX_MULT_TRANSPARENT_EN
    always_comb begin
        for (int i = 0; i < FX_BYTES_PER_WORD; i++)
            eff[i] = mask[i] & (|data[8*i +: 8]);
    end
`else
    logic unused_data;
    assign unused_data = ^data;
    assign eff = mask;
`endif
    assign idx = eff[0] ? 2'd0 : eff[1] ? 2'd1 : eff[2] ? 2'd2 : 2'd3;
    assign any = |eff;
endmodule

// File: rtl/fx_mult_result_writer.sv
// fx_mult_result_writer: captures a MAC result and writes its masked bytes to VRAM one at a time
//   clk, rst_n        clock, asynchronous active-low reset
//   start             1-cycle request to write the current MAC result
//   addr_base         target byte address (low two bits ignored)
//   byte_mask         bytes of the result to write, sampled with start
//   mult_result       MAC output, valid MULT_LAT cycles after start
//   busy, done        transfer in progress / 1-cycle completion pulse
//   start_dropped     1-cycle pulse for a start that arrived while busy
//   vram_wr_req/addr/data/ack   byte write port with req/ack handshake
// Optional feature macro: FX_MULT_TRANSPARENT_EN (zero bytes are skipped).
module fx_mult_result_writer
    import vera_fx_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic [3:0]        byte_mask,
    input  logic [31:0]       mult_result,
    output logic              busy,
    output logic              done,
    output logic              start_dropped,
    output logic              vram_wr_req,
    output logic [ADDR_W-1:0] vram_wr_addr,
    output logic [7:0]        vram_wr_data,
    input  logic              vram_wr_ack
);
    localparam logic [1:0] LAT_LAST = 2'(MULT_LAT == 0 ? 0 : MULT_LAT - 1);

    fx_wr_state_t                 state, nxt;
    logic [1:0]                   cnt;
    logic [31:0]                  hold;
    logic [FX_BYTES_PER_WORD-1:0] rem;
    logic [ADDR_W-3:0]            base_hi;
    logic [FX_BYTE_IDX_W-1:0]     idx;
    logic                         any;

    // The byte in flight is removed from rem when it is selected, so during
    // WRITE the picker already reports whether anything is left; the last ack
    // then goes straight to FIN instead of through an empty SEL.
    fx_byte_pick u_pick (
        .mask (rem),
        .data (hold),
        .idx  (idx),
        .any  (any)
    );

    assign vram_wr_req = state == WRITE;
    assign busy        = state != IDLE && state != FIN;
    assign done        = state == FIN;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (MULT_LAT == 0 ? CAPTURE : WAIT) : IDLE;
            WAIT:    nxt = cnt == LAT_LAST ? CAPTURE : WAIT;
            CAPTURE: nxt = SEL;
            SEL:     nxt = any ? WRITE : FIN;
            WRITE:   nxt = vram_wr_ack ? (any ? SEL : FIN) : WRITE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold          <= '0;
            rem           <= '0;
            base_hi       <= '0;
            start_dropped <= 1'b0;
            vram_wr_addr  <= '0;
            vram_wr_data  <= '0;
        end else begin
            state         <= nxt;
            start_dropped <= start && state != IDLE;
            case (state)
                IDLE: if (start) begin
                    base_hi <= addr_base[ADDR_W-1:2];
                    rem     <= byte_mask;
                    cnt     <= '0;
                end
                WAIT:    cnt <= cnt + 2'd1;
                CAPTURE: hold <= mult_result;
                SEL: if (any) begin
                    rem[idx]     <= 1'b0;
                    vram_wr_addr <= {base_hi, idx};
                    vram_wr_data <= hold[{idx, 3'b000} +: 8];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_mult_result_writer.sv
// tb_fx_mult_result_writer: scoreboard bench for fx_mult_result_writer (MULT_LAT=1)
module tb_fx_mult_result_writer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [16:0] addr_base = '0;
    logic [3:0]  byte_mask = '0;
    logic [31:0] mult_result = '0;
    logic        busy, done, start_dropped, vram_wr_req;
    logic [16:0] vram_wr_addr;
    logic [7:0]  vram_wr_data;
    logic        vram_wr_ack = 0;

    int total = 0, bad = 0;
    int ack_dly = 0;
    int done_cnt = 0, drop_cnt = 0;
    logic [24:0] exp_q[$];

    fx_mult_result_writer #(.ADDR_W(17), .MULT_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_base(addr_base),
        .byte_mask(byte_mask), .mult_result(mult_result), .busy(busy), .done(done),
        .start_dropped(start_dropped), .vram_wr_req(vram_wr_req),
        .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data), .vram_wr_ack(vram_wr_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ack driver and write monitor: raises ack after ack_dly held cycles and
    // checks the accepted byte against the scoreboard queue.
    initial begin
        int wc = 0;
        logic prev_req = 0, prev_ack = 0;
        logic [24:0] prev_wr = '0, e;
        forever begin
            @(negedge clk);
            if (vram_wr_req && !vram_wr_ack) begin
                if (prev_req && !prev_ack)
                    chk("wr_stable", {39'd0, vram_wr_addr, vram_wr_data}, {39'd0, prev_wr});
                if (wc >= ack_dly) begin
                    vram_wr_ack = 1;
                    wc = 0;
                    if (exp_q.size() == 0)
                        chk("unexpected_wr", {39'd0, vram_wr_addr, vram_wr_data}, 64'h1_0000_0000);
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_addr_data", {39'd0, vram_wr_addr, vram_wr_data}, {39'd0, e});
                    end
                end else wc++;
            end else begin
                vram_wr_ack = 0;
                wc = 0;
            end
            prev_req = vram_wr_req;
            prev_ack = vram_wr_ack;
            prev_wr  = {vram_wr_addr, vram_wr_data};
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (start_dropped) drop_cnt++;
    end

    task automatic push_exp(input logic [16:0] a, input logic [3:0] m, input logic [31:0] r);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = r[8*i +: 8];
`ifdef FX_MULT_TRANSPARENT_EN
            if (m[i] && b != 8'h00) exp_q.push_back({a[16:2], 2'(i), b});
`else
            if (m[i]) exp_q.push_back({a[16:2], 2'(i), b});
`endif
        end
    endtask

    // One transfer: start in cycle 0, optional dropped start in cycle `inject`,
    // mult_result scrambled once captured; checks done cycle and busy length.
    task automatic run(input string nm, input logic [16:0] a, input logic [3:0] m,
                       input logic [31:0] r, input int dly, input int inject,
                       input int exp_n, input int exp_busy);
        int n = 1, nb = 0, d0, dr0;
        ack_dly = dly;
        push_exp(a, m, r);
        d0 = done_cnt;
        dr0 = drop_cnt;
        start = 1; addr_base = a; byte_mask = m; mult_result = r;
        @(negedge clk);
        start = 0;
        while (n < 200 && !done) begin
            if (busy) nb++;
            if (n == 3) mult_result = 32'hA5A5_5A5A;
            start = (n == inject);
            if (start) begin addr_base = ~a; byte_mask = ~m; end
            @(negedge clk);
            start = 0;
            n++;
        end
        chk({nm, "_no_timeout"}, 64'(n < 200), 64'd1);
        chk({nm, "_done_cycle"}, 64'(n), 64'(exp_n));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk({nm, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({nm, "_drops"}, 64'(drop_cnt - dr0), 64'(inject > 0));
        chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int k, d0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {36'd0, vram_wr_req, busy, done, start_dropped, vram_wr_addr, vram_wr_data}, 64'd0);
        rst_n = 1;
        @(negedge clk);

        run("full", 17'h1_2345, 4'b1111, 32'hDEAD_BEEF, 0, 4, 11, 10);
        run("sparse", 17'h0_ABC8, 4'b1010, 32'h1122_3344, 3, 0, 13, 12);
        run("empty", 17'h0_0010, 4'b0000, 32'h1234_5678, 0, 0, 4, 3);

        // reset while the second byte is waiting for its ack
        ack_dly = 5;
        push_exp(17'h0_0100, 4'b1111, 32'hCAFE_F00D);
        d0 = done_cnt;
        start = 1; addr_base = 17'h0_0100; byte_mask = 4'b1111; mult_result = 32'hCAFE_F00D;
        @(negedge clk);
        start = 0;
        k = 0;
        while (k < 100 && !(vram_wr_req && vram_wr_addr[1:0] == 2'd1)) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reached_byte1", 64'(k < 100), 64'd1);
        rst_n = 0;
        #1;
        chk("rst_outputs", {61'd0, vram_wr_req, busy, done}, 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        rst_n = 1;
        @(negedge clk);

`ifdef FX_MULT_TRANSPARENT_EN
        run("transparent", 17'h1_FFFC, 4'b1111, 32'h00FF_0000, 0, 0, 5, 4);
`else
        run("transparent", 17'h1_FFFC, 4'b1111, 32'h00FF_0000, 0, 0, 11, 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
